// File: rtl/window_handler.sv
// Search-window loader: fills an 80x80 byte array from word memory, then walks every
// 16x16 sub-window in raster order toward the correlation engine under ready/ack.
module window_handler (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [31:0]                input_data,
   input  logic                       ack,
   output logic [6:0]                 row,
   output logic [6:0]                 col,
   output logic [15:0][15:0][7:0]     window_data,
   output logic                       window_ready,
   output logic                       receive,
   output logic                       done,
   output logic [3:0]                 LEDs
);

   localparam int unsigned WIN_DIM  = 80;
   localparam int unsigned SUB_DIM  = 16;
   localparam int unsigned WPR      = WIN_DIM / 4;
   localparam int unsigned AW       = 7;
   localparam int unsigned LAST_POS = WIN_DIM - SUB_DIM;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_PRESENT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   row_q, row_d;
   logic [AW-1:0]   col_q, col_d;
   logic [AW-1:0]   store_row_q, store_row_d;
   logic [AW-1:0]   store_col_q, store_col_d;
   logic            store_vld_q, store_vld_d;
   logic            issue_done_q, issue_done_d;
   logic [AW-1:0]   win_r_q, win_r_d;
   logic [AW-1:0]   win_c_q, win_c_d;
   logic            ready_q, ready_d;
   logic            receive_q, receive_d;
   logic            done_q, done_d;
   logic [3:0]      leds_q, leds_d;
   logic            mem_we;

   logic [7:0]      mem_q [0:WIN_DIM-1][0:WIN_DIM-1];

   // Next-state, address sequencing and registered output values
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      store_row_d  = store_row_q;
      store_col_d  = store_col_q;
      store_vld_d  = store_vld_q;
      issue_done_d = issue_done_q;
      win_r_d      = win_r_q;
      win_c_d      = win_c_q;
      mem_we       = rst_n && (state_q == S_LOAD) && store_vld_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (en) begin
               state_d      = S_LOAD;
               row_d        = '0;
               col_d        = '0;
               store_vld_d  = 1'b0;
               issue_done_d = 1'b0;
            end
         end
         S_LOAD: begin
            store_row_d = row_q;
            store_col_d = col_q;
            store_vld_d = !issue_done_q;
            if (issue_done_q) begin
               state_d = S_PRESENT;
               win_r_d = '0;
               win_c_d = '0;
            end else if (row_q == AW'(WIN_DIM - 1) && col_q == AW'(WPR - 1)) begin
               issue_done_d = 1'b1;
            end else if (col_q == AW'(WPR - 1)) begin
               col_d = '0;
               row_d = row_q + AW'(1);
            end else begin
               col_d = col_q + AW'(1);
            end
         end
         S_PRESENT: begin
            if (ack) begin
               if (win_c_q == AW'(LAST_POS)) begin
                  win_c_d = '0;
                  if (win_r_q == AW'(LAST_POS)) begin
                     state_d = S_DONE;
                  end else begin
                     win_r_d = win_r_q + AW'(1);
                  end
               end else begin
                  win_c_d = win_c_q + AW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d   = (state_d == S_PRESENT);
      receive_d = (state_d == S_LOAD);
      done_d    = (state_d == S_DONE);
      leds_d    = 4'b0001 << state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         store_row_q  <= '0;
         store_col_q  <= '0;
         store_vld_q  <= 1'b0;
         issue_done_q <= 1'b0;
         win_r_q      <= '0;
         win_c_q      <= '0;
         ready_q      <= 1'b0;
         receive_q    <= 1'b0;
         done_q       <= 1'b0;
         leds_q       <= 4'b0001;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         store_row_q  <= store_row_d;
         store_col_q  <= store_col_d;
         store_vld_q  <= store_vld_d;
         issue_done_q <= issue_done_d;
         win_r_q      <= win_r_d;
         win_c_q      <= win_c_d;
         ready_q      <= ready_d;
         receive_q    <= receive_d;
         done_q       <= done_d;
         leds_q       <= leds_d;
      end
   end

   // Word lands big-endian: byte 0 of the stored row segment is input_data[31:24]
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[store_row_q][AW'({store_col_q, 2'(i)})] <= input_data[8*(3-i) +: 8];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < SUB_DIM; r++) begin
         for (int c = 0; c < SUB_DIM; c++) begin
            window_data[r][c] = mem_q[win_r_q + AW'(r)][win_c_q + AW'(c)];
         end
      end
   end

   assign row          = row_q;
   assign col          = col_q;
   assign window_ready = ready_q;
   assign receive      = receive_q;
   assign done         = done_q;
   assign LEDs         = leds_q;

endmodule

// File: tb/tb_window_handler.sv
// Bench for window_handler: word-memory model, scoreboard of expected sub-windows
// consumed by a monitor on every accepted handshake, plus directed control checks.
module tb_window_handler;

   logic                   clk;
   logic                   rst_n;
   logic                   en;
   logic [31:0]            input_data;
   logic                   ack;
   logic [6:0]             row;
   logic [6:0]             col;
   logic [15:0][15:0][7:0] window_data;
   logic                   window_ready;
   logic                   receive;
   logic                   done;
   logic [3:0]             LEDs;

   typedef struct packed {
      logic [15:0][15:0][7:0] data;
      logic [31:0]            r;
      logic [31:0]            c;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] ref_mem [80][80];
   int         pattern;
   int         total;
   int         bad;
   int         wr;
   int         wc;

   window_handler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .input_data   (input_data),
      .ack          (ack),
      .row          (row),
      .col          (col),
      .window_data  (window_data),
      .window_ready (window_ready),
      .receive      (receive),
      .done         (done),
      .LEDs         (LEDs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input int k, input int pat);
      if (pat == 0) return 32'(k);
      return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // External memory: address_translator set 0, one-cycle read latency
   always @(posedge clk) begin
      input_data <= word_of(65 + int'(row) * 20 + int'(col) - 65, pattern);
   end

   task automatic fill_ref(input int pat);
      logic [31:0] w;
      for (int r = 0; r < 80; r++) begin
         for (int c = 0; c < 20; c++) begin
            w = word_of(r * 20 + c, pat);
            for (int i = 0; i < 4; i++) ref_mem[r][4*c+i] = w[8*(3-i) +: 8];
         end
      end
   endtask

   function automatic logic [15:0][15:0][7:0] exp_window(input int r0, input int c0);
      logic [15:0][15:0][7:0] w;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) w[r][c] = ref_mem[r0+r][c0+c];
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: every accepted sub-window is compared against the scoreboard head
   always @(negedge clk) begin
      if (window_ready === 1'b1 && ack === 1'b1) begin
         exp_t e;
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: window accepted with empty scoreboard");
         end else begin
            e = sb_q.pop_front();
            if (window_data !== e.data) begin
               bad++;
               $display("FAIL sb_window(%0d,%0d): got [0][0]=%0h [15][15]=%0h expected [0][0]=%0h [15][15]=%0h",
                        e.r, e.c, window_data[0][0], window_data[15][15], e.data[0][0], e.data[15][15]);
            end
         end
      end
   end

   task automatic pulse_en;
      @(posedge clk); #1 en = 1'b1;
      @(posedge clk); #1 en = 1'b0;
   endtask

   // Counts receive-high cycles, checks issued row/col sequence and ignores a mid-load en
   task automatic wait_load(input string tag);
      int n;
      int addr_err;
      n = 0;
      addr_err = 0;
      while (receive === 1'b1 && n < 3000) begin
         if (n < 1600) begin
            if (int'(row) != n / 20 || int'(col) != n % 20) addr_err++;
         end else if (row != 7'd79 || col != 7'd19) begin
            addr_err++;
         end
         if (n == 500) en = 1'b1;
         if (n == 501) en = 1'b0;
         n++;
         @(posedge clk); #1;
      end
      check({tag, "_load_cycles"}, 32'(n), 32'd1601);
      check({tag, "_load_addr_errs"}, 32'(addr_err), 32'd0);
      check({tag, "_ready_after_load"}, 32'(window_ready), 32'd1);
      check({tag, "_leds_present"}, 32'(LEDs), 32'b0100);
      wr = 0;
      wc = 0;
   endtask

   task automatic present_acks(input int n);
      int i;
      int g;
      exp_t e;
      i = 0;
      g = 0;
      while (i < n) begin
         if ((g % 5) == 4) begin
            ack = 1'b0;
         end else begin
            ack = 1'b1;
            e.data = exp_window(wr, wc);
            e.r = 32'(wr);
            e.c = 32'(wc);
            sb_q.push_back(e);
            if (wc == 64) begin
               wc = 0;
               wr++;
            end else begin
               wc++;
            end
            i++;
         end
         g++;
         @(posedge clk); #1;
      end
      ack = 1'b0;
   endtask

   initial begin
      logic [7:0] first_row [16];
      first_row = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                    8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
      total   = 0;
      bad     = 0;
      pattern = 0;
      wr      = 0;
      wc      = 0;
      rst_n   = 1'b0;
      en      = 1'b1;
      ack     = 1'b0;
      fill_ref(0);

      // Reset with en asserted: reset wins
      @(posedge clk); @(posedge clk); #1;
      check("rst_ready", 32'(window_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_receive", 32'(receive), 32'd0);
      check("rst_leds", 32'(LEDs), 32'b0001);
      check("rst_row_col", {18'd0, row, col}, 32'd0);
      rst_n = 1'b1;
      en    = 1'b0;
      ack   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_ack_ignored", 32'(LEDs), 32'b0001);
      ack = 1'b0;

      // Load pattern 0 and inspect the first window
      pulse_en();
      check("load_receive", 32'(receive), 32'd1);
      check("load_leds", 32'(LEDs), 32'b0010);
      wait_load("p0");
      for (int c = 0; c < 16; c++) check("first_row_bytes", 32'(window_data[0][c]), 32'(first_row[c]));
      check("first_15_15", 32'(window_data[15][15]), 32'h2F);

      // Step one full window row
      present_acks(65);
      check("step_row1_c3", 32'(window_data[0][3]), 32'h14);
      check("step_row1_c0", 32'(window_data[0][0]), 32'h00);
      check("step_row1_ready", 32'(window_ready), 32'd1);

      // Hold with ack low
      repeat (10) @(posedge clk);
      #1;
      check("hold_data", 32'(window_data !== exp_window(1, 0)), 32'd0);
      check("hold_leds", 32'(LEDs), 32'b0100);

      // Walk to the last position and check the bottom-right corner
      present_acks(4225 - 65 - 1);
      check("last_w_15_12", 32'(window_data[15][12]), 32'h00);
      check("last_w_15_13", 32'(window_data[15][13]), 32'h00);
      check("last_w_15_14", 32'(window_data[15][14]), 32'h06);
      check("last_w_15_15", 32'(window_data[15][15]), 32'h3F);
      present_acks(1);
      check("done_flag", 32'(done), 32'd1);
      check("done_ready", 32'(window_ready), 32'd0);
      check("done_leds", 32'(LEDs), 32'b1000);
      ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ack = 1'b0;
      check("done_ack_ignored", 32'(LEDs), 32'b1000);

      // Restart from DONE with a different memory image
      pattern = 1;
      fill_ref(1);
      pulse_en();
      check("restart_done_clr", 32'(done), 32'd0);
      check("restart_receive", 32'(receive), 32'd1);
      wait_load("p1");
      present_acks(4225);
      check("p1_done", 32'(done), 32'd1);

      // Reset in the middle of a load
      pattern = 0;
      fill_ref(0);
      pulse_en();
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check("midload_rst_leds", 32'(LEDs), 32'b0001);
      check("midload_rst_receive", 32'(receive), 32'd0);
      check("midload_rst_row_col", {18'd0, row, col}, 32'd0);
      rst_n = 1'b1;
      pulse_en();
      wait_load("p2");
      present_acks(70);

      @(posedge clk); #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
